traffic_light_ctrl: RTL and testbench

- Parametrised N-approach intersection controller. Successor to the fixed 2-road sensor-driven light FSM.
- Adds programmable green min/max, yellow and all-red timing counted in ticks of an external prescaled enable.
- Adds latched round-robin demand service across NUM_DIR approaches, gap-out/max-out, and emergency preemption.
- Sits between road sensor conditioning and the lamp drivers.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/tl_rr_pick.sv | 36 +++
 rtl/traffic_light_ctrl.sv | 145 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg: lamp codes, phase encoding and width helpers shared by   |
// | the intersection controller.                                          |
// | Rev 1.0 - initial N-approach release                                  |
// +----------------------------------------------------------------------+
package traffic_pkg;

  localparam logic [1:0] c_LAMP_GREEN  = 2'b00;
  localparam logic [1:0] c_LAMP_YELLOW = 2'b01;
  localparam logic [1:0] c_LAMP_RED    = 2'b10;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

  function automatic int dir_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lamp shown by the approach that owns the current cycle.
  function automatic logic [1:0] phase_lamp(input phase_t p);
    case (p)
      PH_GREEN:  return c_LAMP_GREEN;
      PH_YELLOW: return c_LAMP_YELLOW;
      default:   return c_LAMP_RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_rr_pick: first pending approach after cur_dir, round-robin order.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tl_rr_pick
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 2
) (
  input  logic [NUM_DIR-1:0]            demand,
  input  logic [dir_width(NUM_DIR)-1:0] cur_dir,
  output logic [dir_width(NUM_DIR)-1:0] next_dir,
  output logic                          any
);

  localparam int DW = dir_width(NUM_DIR);

  logic [DW-1:0] w_idx;

  // Walk from the farthest offset back to the nearest so the nearest wins.
  always_comb begin
    next_dir = cur_dir;
    any      = 1'b0;
    w_idx    = '0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      w_idx = DW'((int'(cur_dir) + k) % NUM_DIR);
      if (demand[w_idx]) begin
        next_dir = w_idx;
        any      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_light_ctrl: N-approach signal controller with min/max green,  |
// | round-robin demand service and emergency preemption.                  |
// | Rev 1.0 - initial N-approach release                                  |
// +----------------------------------------------------------------------+
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 2,
  parameter int TW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [NUM_DIR-1:0]            sensor,
  input  logic                          preempt,
  input  logic [dir_width(NUM_DIR)-1:0] preempt_dir,
  output logic [2*NUM_DIR-1:0]          lights,
  output logic [dir_width(NUM_DIR)-1:0] cur_dir,
  output logic [1:0]                    phase,
  output logic [NUM_DIR-1:0]            demand
);

  localparam int DW = dir_width(NUM_DIR);

  localparam logic [TW:0] c_GMIN = (TW+1)'(GREEN_MIN);
  localparam logic [TW:0] c_GMAX = (TW+1)'(GREEN_MAX);
  localparam logic [TW:0] c_YEL  = (TW+1)'(YELLOW_T);
  localparam logic [TW:0] c_AR   = (TW+1)'(ALLRED_T);

  phase_t             r_phase, w_phase_nxt;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic [DW-1:0]      r_cur, w_cur_nxt;
  logic [NUM_DIR-1:0] r_demand, w_demand_nxt;

  logic [NUM_DIR-1:0] w_cur_mask;
  logic               w_other;
  logic               w_pre;
  logic               w_pre_here;
  logic [TW:0]        w_t1;
  logic [TW-1:0]      w_timer_inc;
  logic [DW-1:0]      w_pick;
  logic               w_any;
  logic [DW-1:0]      w_next_rr;

  tl_rr_pick #(
    .NUM_DIR (NUM_DIR)
  ) u_rr_pick (
    .demand   (r_demand),
    .cur_dir  (r_cur),
    .next_dir (w_pick),
    .any      (w_any)
  );

  assign w_cur_mask  = NUM_DIR'(1) << r_cur;
  assign w_other     = |(r_demand & ~w_cur_mask);
  // Out-of-range preemption targets are ignored entirely.
  assign w_pre       = preempt && (int'(preempt_dir) < NUM_DIR);
  assign w_pre_here  = w_pre && (preempt_dir == r_cur);
  assign w_t1        = {1'b0, r_timer} + (TW+1)'(1);
  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + TW'(1);
  assign w_next_rr   = w_any ? w_pick : DW'((int'(r_cur) + 1) % NUM_DIR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase  <= PH_GREEN;
      r_timer  <= '0;
      r_cur    <= '0;
      r_demand <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_timer  <= w_timer_nxt;
      r_cur    <= w_cur_nxt;
      r_demand <= w_demand_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_timer_nxt  = r_timer;
    w_cur_nxt    = r_cur;
    w_demand_nxt = r_demand | (sensor & ~w_cur_mask);
    case (r_phase)
      PH_GREEN: begin
        // Preemption is decided before any tick-based evaluation.
        if (w_pre) begin
          if (!w_pre_here) begin
            w_phase_nxt = PH_YELLOW;
            w_timer_nxt = '0;
          end
        end else if (tick) begin
          if (w_other && ((w_t1 >= c_GMAX) ||
                          ((w_t1 >= c_GMIN) && !sensor[r_cur]))) begin
            w_phase_nxt = PH_YELLOW;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end
      PH_YELLOW: begin
        if (tick) begin
          if (w_t1 == c_YEL) begin
            w_phase_nxt = PH_ALLRED;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end
      PH_ALLRED: begin
        if (tick) begin
          if (w_t1 == c_AR) begin
            w_phase_nxt  = PH_GREEN;
            w_timer_nxt  = '0;
            w_cur_nxt    = w_pre ? preempt_dir : w_next_rr;
            w_demand_nxt = w_demand_nxt & ~(NUM_DIR'(1) << w_cur_nxt);
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end
      default: begin
        w_phase_nxt = PH_GREEN;
        w_timer_nxt = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    assign lights[2*i+1:2*i] = (r_cur == DW'(i)) ? phase_lamp(r_phase)
                                                 : c_LAMP_RED;
  end

  assign cur_dir = r_cur;
  assign phase   = r_phase;
  assign demand  = r_demand;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_light_ctrl: directed checks on 2- and 4-approach builds.   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_traffic_light_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;

  logic [1:0] s2;
  logic       pre2;
  logic [0:0] pd2;
  logic [3:0] l2;
  logic [0:0] cd2;
  logic [1:0] ph2;
  logic [1:0] dm2;

  logic [3:0] s4;
  logic       pre4;
  logic [1:0] pd4;
  logic [7:0] l4;
  logic [1:0] cd4;
  logic [1:0] ph4;
  logic [3:0] dm4;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_ctrl #(.NUM_DIR(2)) u_dut2 (
    .clock(clock), .reset(reset), .tick(tick), .sensor(s2),
    .preempt(pre2), .preempt_dir(pd2), .lights(l2), .cur_dir(cd2),
    .phase(ph2), .demand(dm2)
  );

  traffic_light_ctrl #(.NUM_DIR(4)) u_dut4 (
    .clock(clock), .reset(reset), .tick(tick), .sensor(s4),
    .preempt(pre4), .preempt_dir(pd4), .lights(l4), .cur_dir(cd4),
    .phase(ph4), .demand(dm4)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    s2 = '0; pre2 = 1'b0; pd2 = '0;
    s4 = '0; pre4 = 1'b0; pd4 = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Idle 2-way: approach 0 green forever.
    check("rst_phase", 32'(ph2), 32'd0);
    check("rst_cur",   32'(cd2), 32'd0);
    check("rst_dem",   32'(dm2), 32'd0);
    check("rst_lights", 32'(l2), 32'h8);
    for (int k = 0; k < 40; k++) begin
      ticks(1);
      check("idle_lights", 32'(l2), 32'h8);
    end
    check("idle_phase", 32'(ph2), 32'd0);
    check("idle_cur",   32'(cd2), 32'd0);

    // Gap-out: demand on 1, approach 0 empty.
    do_reset();
    s2 = 2'b10; cyc(); s2 = 2'b00;
    check("gap_dem_set", 32'(dm2), 32'h2);
    ticks(3);
    check("gap_t3_green", 32'(ph2), 32'd0);
    ticks(1);
    check("gap_t4_yel", 32'(ph2), 32'd1);
    check("gap_t4_lights", 32'(l2), 32'h9);
    cyc();
    check("gap_notick_hold", 32'(ph2), 32'd1);
    ticks(1);
    check("gap_t5_yel", 32'(ph2), 32'd1);
    ticks(1);
    check("gap_t6_ar", 32'(ph2), 32'd2);
    check("gap_t6_lights", 32'(l2), 32'hA);
    ticks(1);
    check("gap_t7_green", 32'(ph2), 32'd0);
    check("gap_t7_cur", 32'(cd2), 32'd1);
    check("gap_t7_lights", 32'(l2), 32'h2);
    check("gap_t7_dem", 32'(dm2), 32'h0);

    // Max-out: approach 0 keeps its sensor busy.
    do_reset();
    s2 = 2'b11; cyc(); s2 = 2'b01;
    ticks(15);
    check("max_t15_green", 32'(ph2), 32'd0);
    ticks(1);
    check("max_t16_yel", 32'(ph2), 32'd1);
    ticks(1);
    check("max_t17_yel", 32'(ph2), 32'd1);
    ticks(1);
    check("max_t18_ar", 32'(ph2), 32'd2);
    ticks(1);
    check("max_t19_green", 32'(ph2), 32'd0);
    check("max_t19_cur", 32'(cd2), 32'd1);
    check("max_dem0_set", 32'(dm2), 32'h1);
    s2 = 2'b00;

    // 4-way round robin over pending 2 and 3.
    do_reset();
    s4 = 4'b1100; cyc(); s4 = 4'b0000;
    check("rr_dem", 32'(dm4), 32'hC);
    ticks(4);
    check("rr_yel0", 32'(ph4), 32'd1);
    ticks(3);
    check("rr_green2", 32'(ph4), 32'd0);
    check("rr_cur2", 32'(cd4), 32'd2);
    check("rr_lights2", 32'(l4), 32'h8A);
    check("rr_dem2", 32'(dm4), 32'h8);
    ticks(4);
    check("rr_yel2", 32'(ph4), 32'd1);
    ticks(3);
    check("rr_cur3", 32'(cd4), 32'd3);
    check("rr_lights3", 32'(l4), 32'h2A);
    check("rr_dem3", 32'(dm4), 32'h0);

    // Preemption toward 2 from green 0 without a tick.
    do_reset();
    ticks(1);
    pre4 = 1'b1; pd4 = 2'd2;
    cyc();
    check("pre_yel_now", 32'(ph4), 32'd1);
    check("pre_yel_lights", 32'(l4), 32'hA9);
    ticks(2);
    check("pre_ar", 32'(ph4), 32'd2);
    ticks(1);
    check("pre_green", 32'(ph4), 32'd0);
    check("pre_cur2", 32'(cd4), 32'd2);
    s4 = 4'b0010; cyc(); s4 = 4'b0000;
    check("pre_dem1", 32'(dm4), 32'h2);
    ticks(20);
    check("pre_hold_phase", 32'(ph4), 32'd0);
    check("pre_hold_cur", 32'(cd4), 32'd2);
    pre4 = 1'b0;
    ticks(3);
    check("pre_frozen_t3", 32'(ph4), 32'd0);
    ticks(1);
    check("pre_frozen_t4", 32'(ph4), 32'd1);

    // Preempt dropped mid-sequence with nothing pending: next in order.
    do_reset();
    pre4 = 1'b1; pd4 = 2'd2;
    cyc();
    pre4 = 1'b0;
    check("drop_yel", 32'(ph4), 32'd1);
    ticks(2);
    check("drop_ar", 32'(ph4), 32'd2);
    ticks(1);
    check("drop_green", 32'(ph4), 32'd0);
    check("drop_cur1", 32'(cd4), 32'd1);

    // Asynchronous reset while yellow.
    do_reset();
    s4 = 4'b0010; cyc(); s4 = 4'b0000;
    ticks(4);
    check("arst_pre_yel", 32'(ph4), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_phase", 32'(ph4), 32'd0);
    check("arst_cur", 32'(cd4), 32'd0);
    check("arst_dem", 32'(dm4), 32'h0);
    check("arst_lights", 32'(l4), 32'hA8);
    cyc();
    reset = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
